inc_rr_arbiter: RTL and testbench
=================================

Name: inc_rr_arbiter

Overview:
- Shares one incrementer datapath (d = a + 1) among NREQ requesters using round-robin arbitration.
- Each accepted request produces a registered response carrying the result, the requester ID and an overflow flag, under valid/ready backpressure.
- Sits between HLS-generated state machines that each need an occasional increment and the single shared INC resource.

Parameters:
- DATAWIDTH, 64, width of each operand and of the result.
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, 2, width of rsp_id; must equal ceil(log2(NREQ)).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; bit i belongs to requester i.
- a_flat  input  NREQ*DATAWIDTH  operands; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- gnt  output  NREQ  one-hot grant, combinational; high in the cycle requester i's operand is captured.
- rsp_valid  output  1  response register holds a valid result.
- rsp_ready  input  1  consumer accepts the response this cycle.
- rsp_data  output  DATAWIDTH  a + 1 of the granted operand.
- rsp_id  output  IDW  index of the requester that produced rsp_data.
- rsp_ovf  output  1  operand was all-ones, so the result wrapped.

Behaviour:
- Reset (Rst=1 at a clock edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, round-robin pointer ptr=0.
  - gnt forced to 0 while Rst=1.
  - A pending response is dropped.
- Capture condition: cap = (!rsp_valid || rsp_ready) && |req && !Rst.
- Arbitration:
  - When cap=1, grant the first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - gnt[i]=1 in that cycle only; at most one gnt bit is ever high.
- On the edge where cap=1:
  - rsp_data <= a_i + 1, truncated to DATAWIDTH.
  - rsp_id <= i.
  - rsp_ovf <= (a_i == all-ones).
  - rsp_valid <= 1.
  - ptr <= (i+1) mod NREQ.
- Latency: one cycle from grant to rsp_valid.
- Throughput: one result per cycle while rsp_ready=1 and requests are present.
- Backpressure: if rsp_valid=1 and rsp_ready=0:
  - rsp_data, rsp_id and rsp_ovf hold.
  - gnt=0; ptr holds.
- Response drain: if rsp_valid=1, rsp_ready=1 and no req, rsp_valid <= 0 and the data fields hold their last values.
- Simultaneous events:
  - Consume and capture in the same cycle is allowed (pipelined handoff, no bubble).
  - Multiple requests are resolved by ptr only.
- Requester contract:
  - Hold req and the operand stable until gnt is seen.
  - Dropping req before grant is legal; that request is simply not served.
  - A requester that keeps req high after grant is served again when its round-robin turn recurs.
- Fairness: with all NREQ requesting continuously and rsp_ready=1, the grant order is 0,1,...,NREQ-1,0,...
- ptr advances only on a grant, never on idle cycles.

Optional Feature:
- Macro INC_RR_ARBITER_SAT_EN.
- Defined: saturating increment. An all-ones operand yields rsp_data = all-ones, with rsp_ovf=1; all other operands yield a+1.
- Undefined: wrapping increment as in Behaviour. All-ones yields 0, with rsp_ovf=1.
- Arbitration, latency and handshake are identical in both builds.

Test Plan:
- Run every scenario with DATAWIDTH=8 and NREQ=4.
- Reset mid-stream: rsp_valid=1 held by rsp_ready=0, then assert Rst for one cycle -> next cycle rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, gnt=0; the first grant after reset goes to requester 0.
- Single request: req=4'b0100, a2=8'h1F, rsp_ready=1 -> gnt=4'b0100 in the same cycle; next cycle rsp_valid=1, rsp_data=8'h20, rsp_id=2, rsp_ovf=0.
- Round-robin fairness: req=4'b1111 held for 8 cycles, rsp_ready=1, operands a0..a3 = 10,20,30,40 -> rsp_id sequence 0,1,2,3,0,1,2,3; rsp_data sequence 11,21,31,41,... with no bubbles.
- Backpressure: req=4'b0011, rsp_ready=0 for 3 cycles after the first capture -> rsp_id=0 and its data stable, gnt=0 throughout; on rsp_ready=1, requester 1 is granted in that same cycle.
- Wrap/saturate: req=4'b0001, a0=8'hFF -> rsp_ovf=1; rsp_data=8'h00 without the macro, 8'hFF with INC_RR_ARBITER_SAT_EN defined.
- Pointer skip: ptr=1 after granting 0, then req=4'b1001 -> requester 3 is granted before 0; ptr becomes 0, so requester 0 is granted next.

Source files
------------

// File: rtl/inc_rr_arbiter.sv
// inc_rr_arbiter: round-robin arbiter in front of one shared incrementer.
// Requesters present an operand plus a req bit. One of them is granted
// combinationally in the cycle its operand is captured, and the registered
// response carries a+1, the requester id and an overflow flag.
// Optional build macro: INC_RR_ARBITER_SAT_EN. When it is defined, an
// all-ones operand saturates to all-ones instead of wrapping to zero.

// Per-requester operand gate. A requester only drives the shared operand
// bus while it holds the grant, so the bus can be a plain OR of all slots.
module inc_rr_slot #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 gnt,
    input  logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] a_gated
);
    // AND-gate the operand with this slot's grant
    assign a_gated = gnt ? a : '0;
endmodule

module inc_rr_arbiter #(
    parameter int DATAWIDTH = 64,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_flat,
    output logic [NREQ-1:0]           gnt,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATAWIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]            rsp_id,
    output logic                      rsp_ovf
);

    generate
        if (NREQ < 2 || NREQ > 16 || IDW != $clog2(NREQ)) begin : g_bad_cfg
            $error("inc_rr_arbiter: NREQ must be 2..16 and IDW == clog2(NREQ)");
        end
    endgenerate

    // Round-robin pointer: the first requester that gets considered next time
    logic [IDW-1:0] ptr;

    // Arbitration result
    logic [IDW-1:0] sel;
    logic           found;
    logic           cap;

    // Operand path
    logic [NREQ-1:0][DATAWIDTH-1:0] a_gated;
    logic [DATAWIDTH-1:0]           a_sel;
    logic [DATAWIDTH-1:0]           inc_sum;
    logic [DATAWIDTH-1:0]           inc_res;
    logic                           inc_ovf;

    // A new operand may enter when the response slot is empty or is being
    // drained this very cycle. This lets a result hand off with no bubble.
    assign cap = (!rsp_valid || rsp_ready) && (|req) && !Rst;

    // Search ptr, ptr+1, ... modulo NREQ and take the first active request
    always_comb begin
        logic [IDW:0] idx;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (!found && req[idx[IDW-1:0]]) begin
                sel   = idx[IDW-1:0];
                found = 1'b1;
            end
        end
    end

    // Grant is one-hot and only asserted in the capture cycle
    always_comb begin
        gnt = '0;
        if (cap && found)
            gnt[sel] = 1'b1;
    end

    // One gate per requester. Their OR is the single shared operand.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            inc_rr_slot #(.DATAWIDTH(DATAWIDTH)) u_slot (
                .gnt     (gnt[gi]),
                .a       (a_flat[gi*DATAWIDTH +: DATAWIDTH]),
                .a_gated (a_gated[gi])
            );
        end
    endgenerate

    // OR-reduce the gated operands onto the shared bus
    always_comb begin
        a_sel = '0;
        for (int i = 0; i < NREQ; i++)
            a_sel = a_sel | a_gated[i];
    end

    // The shared incrementer. Overflow means the operand was all-ones.
    assign inc_sum = a_sel + DATAWIDTH'(1);
    assign inc_ovf = &a_sel;

`ifdef INC_RR_ARBITER_SAT_EN
    assign inc_res = inc_ovf ? a_sel : inc_sum;
`else
    assign inc_res = inc_sum;
`endif

    // Response register and pointer update
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_ovf   <= 1'b0;
            ptr       <= '0;
        end else if (cap) begin
            rsp_valid <= 1'b1;
            rsp_data  <= inc_res;
            rsp_id    <= sel;
            rsp_ovf   <= inc_ovf;
            ptr       <= (sel == IDW'(NREQ-1)) ? '0 : sel + IDW'(1);
        end else if (rsp_ready) begin
            // Drained with nothing new to take: empty the slot and keep the data
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inc_rr_arbiter.sv
// Directed, table-driven bench for inc_rr_arbiter (DATAWIDTH=8, NREQ=4).
module tb_inc_rr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

`ifdef INC_RR_ARBITER_SAT_EN
    localparam logic [DW-1:0] FF_RES = 8'hFF;
`else
    localparam logic [DW-1:0] FF_RES = 8'h00;
`endif

    logic             Clk = 1'b0;
    logic             Rst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] a_flat;
    logic [NR-1:0]    gnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_id;
    logic             rsp_ovf;

    int errors = 0;
    int checks = 0;

    inc_rr_arbiter #(.DATAWIDTH(DW), .NREQ(NR), .IDW(IW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req       (req),
        .a_flat    (a_flat),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          rst;
        logic [NR-1:0] req;
        logic [DW-1:0] a0, a1, a2, a3;
        logic          rdy;
        logic [NR-1:0] egnt;
        logic          evld;
        logic [DW-1:0] edata;
        logic [IW-1:0] eid;
        logic          eovf;
        string         name;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input string name, input logic rst, input logic [NR-1:0] rq,
                       input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                       input logic [DW-1:0] a2, input logic [DW-1:0] a3,
                       input logic rdy, input logic [NR-1:0] egnt, input logic evld,
                       input logic [DW-1:0] edata, input logic [IW-1:0] eid, input logic eovf);
        vec_t v;
        v.name = name; v.rst = rst; v.req = rq;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.rdy = rdy; v.egnt = egnt; v.evld = evld;
        v.edata = edata; v.eid = eid; v.eovf = eovf;
        tbl.push_back(v);
    endtask

    // Drive one row at the falling edge, check the grant before the rising
    // edge, then check the registered response just after it.
    task automatic apply(input vec_t v, input int row);
        Rst       = v.rst;
        req       = v.req;
        a_flat    = {v.a3, v.a2, v.a1, v.a0};
        rsp_ready = v.rdy;
        #1;
        chk({v.name, ".gnt"}, row, 32'(gnt), 32'(v.egnt));
        @(posedge Clk);
        #1;
        chk({v.name, ".valid"}, row, 32'(rsp_valid), 32'(v.evld));
        chk({v.name, ".data"},  row, 32'(rsp_data),  32'(v.edata));
        chk({v.name, ".id"},    row, 32'(rsp_id),    32'(v.eid));
        chk({v.name, ".ovf"},   row, 32'(rsp_ovf),   32'(v.eovf));
        @(negedge Clk);
    endtask

    initial begin
        int row;
        Rst = 1'b1; req = '0; a_flat = '0; rsp_ready = 1'b0;

        //   name     rst req      a0     a1     a2     a3    rdy gnt     vld data   id ovf
        add("reset",  1, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 0, 4'b0000, 0, 8'h00, 0, 0);
        // fairness, ptr starts at 0, no bubbles
        add("rr",     0, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1, 4'b0001, 1, 8'd11, 0, 0);
        add("rr",     0, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1, 4'b0010, 1, 8'd21, 1, 0);
        add("rr",     0, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1, 4'b0100, 1, 8'd31, 2, 0);
        add("rr",     0, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1, 4'b1000, 1, 8'd41, 3, 0);
        add("rr",     0, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1, 4'b0001, 1, 8'd11, 0, 0);
        add("rr",     0, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1, 4'b0010, 1, 8'd21, 1, 0);
        add("rr",     0, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1, 4'b0100, 1, 8'd31, 2, 0);
        add("rr",     0, 4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1, 4'b1000, 1, 8'd41, 3, 0);
        add("drain",  0, 4'b0000, 8'd10, 8'd20, 8'd30, 8'd40, 1, 4'b0000, 0, 8'd41, 3, 0);
        // backpressure: ptr=0, capture 0, then stall 3 cycles
        add("bp",     0, 4'b0011, 8'h33, 8'h44, 8'h00, 8'h00, 0, 4'b0001, 1, 8'h34, 0, 0);
        add("bp",     0, 4'b0011, 8'h33, 8'h44, 8'h00, 8'h00, 0, 4'b0000, 1, 8'h34, 0, 0);
        add("bp",     0, 4'b0011, 8'h33, 8'h44, 8'h00, 8'h00, 0, 4'b0000, 1, 8'h34, 0, 0);
        add("bp",     0, 4'b0011, 8'h33, 8'h44, 8'h00, 8'h00, 0, 4'b0000, 1, 8'h34, 0, 0);
        add("bp",     0, 4'b0011, 8'h33, 8'h44, 8'h00, 8'h00, 1, 4'b0010, 1, 8'h45, 1, 0);
        add("drain",  0, 4'b0000, 8'h33, 8'h44, 8'h00, 8'h00, 1, 4'b0000, 0, 8'h45, 1, 0);
        // single request, ptr=2
        add("single", 0, 4'b0100, 8'h00, 8'h00, 8'h1F, 8'h00, 1, 4'b0100, 1, 8'h20, 2, 0);
        add("drain",  0, 4'b0000, 8'h00, 8'h00, 8'h1F, 8'h00, 1, 4'b0000, 0, 8'h20, 2, 0);
        // all-ones operand, ptr=3 wraps the search to 0
        add("wrap",   0, 4'b0001, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 1, FF_RES, 0, 1);
        add("drain",  0, 4'b0000, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 0, FF_RES, 0, 1);
        // pointer skip: ptr=1, 3 beats 0, then 0 is next
        add("skip",   0, 4'b1001, 8'h05, 8'h00, 8'h00, 8'h07, 1, 4'b1000, 1, 8'h08, 3, 0);
        add("skip",   0, 4'b1001, 8'h05, 8'h00, 8'h00, 8'h07, 1, 4'b0001, 1, 8'h06, 0, 0);
        add("drain",  0, 4'b0000, 8'h05, 8'h00, 8'h00, 8'h07, 1, 4'b0000, 0, 8'h06, 0, 0);

        @(negedge Clk);
        row = 0;
        foreach (tbl[i]) begin
            apply(tbl[i], row);
            row++;
        end

        // Reset mid-stream: ptr=1 here. Capture 1 and hold it under
        // backpressure, then reset. The first grant afterwards goes to 0.
        begin
            vec_t v;
            v.name = "mrst"; v.a0 = 8'd10; v.a1 = 8'd20; v.a2 = 8'd30; v.a3 = 8'd40;
            v.rst = 0; v.req = 4'b0010; v.rdy = 0; v.egnt = 4'b0010;
            v.evld = 1; v.edata = 8'd21; v.eid = 1; v.eovf = 0;
            apply(v, row++);
            v.req = 4'b0000; v.egnt = 4'b0000;
            apply(v, row++);
            v.rst = 1; v.req = 4'b0100; v.egnt = 4'b0000;
            v.evld = 0; v.edata = 8'h00; v.eid = 0;
            apply(v, row++);
            v.rst = 0; v.req = 4'b1111; v.rdy = 1; v.egnt = 4'b0001;
            v.evld = 1; v.edata = 8'd11; v.eid = 0;
            apply(v, row++);
            v.egnt = 4'b0010; v.edata = 8'd21; v.eid = 1;
            apply(v, row++);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a stuck simulation
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
